// File: rtl/cic_decim_sched.sv
// Sequencing controller for the CIC decimator: input/output strobes,
// programmable rate applied on output boundaries, and warm-up masking.
//
// Ports:
//   clock, reset_n      : clock, async active-low reset
//   enable              : run request
//   sample_strobe       : one-cycle pulse per raw input sample
//   rate_in, rate_wr    : requested rate and its write pulse
//   cic_enable          : decimator enable (high outside IDLE)
//   strobe_in           : registered input-sample strobe
//   strobe_out          : output-sample strobe
//   valid_out           : strobe_out once the comb history has settled
//   rate_cur            : rate in force
//   rate_pending        : a written rate waits for a boundary
//   rate_err            : pulse on a rejected (zero) rate write
//   settling            : high in WARMUP
module cic_decim_sched #(
    parameter int RATE_W       = 8,
    parameter int STAGES       = 4,
    parameter int DEFAULT_RATE = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              sample_strobe,
    input  logic [RATE_W-1:0] rate_in,
    input  logic              rate_wr,
    output logic              cic_enable,
    output logic              strobe_in,
    output logic              strobe_out,
    output logic              valid_out,
    output logic [RATE_W-1:0] rate_cur,
    output logic              rate_pending,
    output logic              rate_err,
    output logic              settling
);

    localparam int WU_W = $clog2(STAGES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [RATE_W-1:0] dec_cnt;
    logic [RATE_W-1:0] dec_nxt;
    logic [WU_W-1:0]   wu_cnt;
    logic [WU_W-1:0]   wu_nxt;
    logic [RATE_W-1:0] rate_pend_val;
    logic              wr_ok;
    logic              apply;

    assign wr_ok = rate_wr && (rate_in != '0);

    // A pending rate lands at once in IDLE, otherwise on the cycle after
    // an output strobe (the value must predate that strobe).
    assign apply = rate_pending &&
                   ((state == IDLE) || (strobe_out && enable));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            dec_cnt <= '0;
            wu_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            dec_cnt <= dec_nxt;
            wu_cnt  <= wu_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        dec_nxt   = dec_cnt;
        wu_nxt    = wu_cnt;
        if (!enable) begin
            state_nxt = IDLE;
            dec_nxt   = '0;
            wu_nxt    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = WARMUP;
                    wu_nxt    = WU_W'(STAGES);
                    dec_nxt   = '0;
                end
                default: begin
                    if (apply) begin
                        // Comb history is stale after a rate change.
                        state_nxt = WARMUP;
                        wu_nxt    = WU_W'(STAGES);
                        dec_nxt   = rate_pend_val - RATE_W'(1);
                    end else if (strobe_in) begin
                        if (dec_cnt == '0)
                            dec_nxt = rate_cur - RATE_W'(1);
                        else
                            dec_nxt = dec_cnt - RATE_W'(1);
                        if (strobe_out && state == WARMUP) begin
                            wu_nxt = wu_cnt - WU_W'(1);
                            if (wu_cnt == WU_W'(1))
                                state_nxt = RUN;
                        end
                    end
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        cic_enable = (state != IDLE);
        settling   = (state == WARMUP);
        strobe_out = strobe_in && (dec_cnt == '0) && (state != IDLE);
        valid_out  = strobe_out && (state == RUN);
    end

    // Strobe, rate and error registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            strobe_in     <= 1'b0;
            rate_err      <= 1'b0;
            rate_cur      <= RATE_W'(DEFAULT_RATE);
            rate_pend_val <= '0;
            rate_pending  <= 1'b0;
        end else begin
            strobe_in <= sample_strobe && enable;
            rate_err  <= rate_wr && (rate_in == '0);
            if (apply)
                rate_cur <= rate_pend_val;
            if (wr_ok) begin
                rate_pend_val <= rate_in;
                rate_pending  <= 1'b1;
            end else if (apply) begin
                rate_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cic_decim_sched.sv
// Self-checking bench for cic_decim_sched: directed scenarios plus
// randomized traffic compared each cycle against a behavioural model.
module tb_cic_decim_sched;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       sample_strobe;
    logic [7:0] rate_in;
    logic       rate_wr;
    logic       cic_enable;
    logic       strobe_in;
    logic       strobe_out;
    logic       valid_out;
    logic [7:0] rate_cur;
    logic       rate_pending;
    logic       rate_err;
    logic       settling;

    int checks = 0;
    int errors = 0;
    bit run_chk = 0;

    cic_decim_sched #(
        .RATE_W(8),
        .STAGES(4),
        .DEFAULT_RATE(16)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .enable(enable),
        .sample_strobe(sample_strobe),
        .rate_in(rate_in),
        .rate_wr(rate_wr),
        .cic_enable(cic_enable),
        .strobe_in(strobe_in),
        .strobe_out(strobe_out),
        .valid_out(valid_out),
        .rate_cur(rate_cur),
        .rate_pending(rate_pending),
        .rate_err(rate_err),
        .settling(settling)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model. m_since counts non-output input strobes since
    // the last output; an output is due once it reaches rate-1.
    int m_st;      // 0 idle, 1 warm-up, 2 run
    bit m_sin;
    int m_since;
    int m_outs;    // outputs seen since warm-up began
    int m_rate;
    int m_pend;
    bit m_pv;
    bit m_err;
    bit m_so;
    bit m_ap;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_st = 0; m_sin = 0; m_since = 0; m_outs = 0;
            m_rate = 16; m_pend = 0; m_pv = 0; m_err = 0;
        end else begin
            m_so = (m_st != 0) && m_sin && (m_since == m_rate - 1);
            m_ap = m_pv && ((m_st == 0) || (m_so && enable));
            if (m_ap) m_rate = m_pend;
            if (!enable) begin
                m_st = 0;
            end else if (m_st == 0) begin
                m_st = 1; m_outs = 0; m_since = m_rate - 1;
            end else if (m_ap) begin
                m_st = 1; m_outs = 0; m_since = 0;
            end else if (m_sin) begin
                m_since = m_so ? 0 : m_since + 1;
                if (m_so && m_st == 1) begin
                    m_outs++;
                    if (m_outs == 4) m_st = 2;
                end
            end
            m_err = rate_wr && (rate_in == 8'd0);
            if (rate_wr && rate_in != 8'd0) begin
                m_pend = int'(rate_in); m_pv = 1;
            end else if (m_ap) begin
                m_pv = 0;
            end
            m_sin = sample_strobe && enable;
        end
    end

    always @(negedge clock) begin
        if (run_chk) begin
            bit eso;
            eso = (m_st != 0) && m_sin && (m_since == m_rate - 1);
            chk("cic_enable", 32'(cic_enable), 32'(m_st != 0));
            chk("settling", 32'(settling), 32'(m_st == 1));
            chk("strobe_in", 32'(strobe_in), 32'(m_sin));
            chk("strobe_out", 32'(strobe_out), 32'(eso));
            chk("valid_out", 32'(valid_out), 32'(eso && m_st == 2));
            chk("rate_cur", 32'(rate_cur), 32'(m_rate));
            chk("rate_pending", 32'(rate_pending), 32'(m_pv));
            chk("rate_err", 32'(rate_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_sout(input int lim);
        int c;
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!strobe_out && c < lim);
        if (!strobe_out) begin
            checks++;
            errors++;
            $display("FAIL wait_sout: timeout after %0d cycles", lim);
        end
    endtask

    initial begin
        int n, ko, i1, i2, fv, k, ns, ec, mism;
        bit done;
        logic [7:0] wv [3];
        reset_n = 1'b1; enable = 1'b0; sample_strobe = 1'b0;
        rate_in = 8'd0; rate_wr = 1'b0;
        #1 reset_n = 1'b0;
        #1 run_chk = 1;
        repeat (3) @(posedge clock);
        chk("reset_rate_cur", 32'(rate_cur), 32'd16);
        chk("reset_cic_enable", 32'(cic_enable), 32'd0);
        #1 reset_n = 1'b1;

        // 1: default rate, strobe every cycle
        enable = 1'b1; sample_strobe = 1'b1;
        n = 0; ko = 0; i1 = 0; i2 = 0; fv = 0;
        repeat (80) begin
            @(negedge clock);
            if (strobe_in) n++;
            if (strobe_out) begin
                ko++;
                if (ko == 1) i1 = n;
                if (ko == 2) i2 = n;
            end
            if (valid_out && fv == 0) fv = n;
        end
        chk("t1_first_out", 32'(i1), 32'd1);
        chk("t1_second_out", 32'(i2), 32'd17);
        chk("t1_first_valid", 32'(fv), 32'd65);

        // 2: rate 4 written mid-period
        repeat (10) tick();
        rate_wr = 1'b1; rate_in = 8'd4;
        tick();
        rate_wr = 1'b0;
        @(negedge clock);
        chk("t2_pending", 32'(rate_pending), 32'd1);
        chk("t2_rate_held", 32'(rate_cur), 32'd16);
        wait_sout(40);
        tick();
        @(negedge clock);
        chk("t2_rate_new", 32'(rate_cur), 32'd4);
        k = 0; done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (strobe_out) begin
                k++;
                if (valid_out) done = 1;
            end
            if (!done) @(negedge clock);
        end
        chk("t2_masked_then_valid", 32'(k), 32'd5);
        ns = 0; done = 0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clock);
            if (strobe_in) ns++;
            if (valid_out) done = 1;
        end
        chk("t2_valid_period", 32'(ns), 32'd4);

        // 3: writes 0, 3, 5 on consecutive cycles
        wv[0] = 8'd0; wv[1] = 8'd3; wv[2] = 8'd5;
        ec = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            rate_wr = (i < 3);
            rate_in = (i < 3) ? wv[i] : 8'd0;
            @(negedge clock);
            if (rate_err) ec++;
        end
        chk("t3_err_pulses", 32'(ec), 32'd1);
        chk("t3_rate", 32'(rate_cur), 32'd5);

        // 4: write coincident with strobe_out
        wait_sout(20);
        repeat (5) tick();
        rate_wr = 1'b1; rate_in = 8'd2;
        @(negedge clock);
        chk("t4_coincident", 32'(strobe_out), 32'd1);
        tick();
        rate_wr = 1'b0;
        @(negedge clock);
        chk("t4_rate_held", 32'(rate_cur), 32'd5);
        chk("t4_pending", 32'(rate_pending), 32'd1);
        wait_sout(20);
        tick();
        @(negedge clock);
        chk("t4_rate_new", 32'(rate_cur), 32'd2);

        // 5: rate 1, strobe every 3rd cycle
        tick();
        enable = 1'b0;
        tick();
        rate_wr = 1'b1; rate_in = 8'd1;
        tick();
        rate_wr = 1'b0;
        tick();
        @(negedge clock);
        chk("t5_rate", 32'(rate_cur), 32'd1);
        n = 0; fv = 0; mism = 0;
        for (int c = 0; c < 36; c++) begin
            tick();
            enable = 1'b1;
            sample_strobe = (c % 3 == 0);
            @(negedge clock);
            if (strobe_in) n++;
            if (strobe_out != strobe_in) mism++;
            if (valid_out && fv == 0) fv = n;
        end
        chk("t5_sout_eq_sin", 32'(mism), 32'd0);
        chk("t5_first_valid", 32'(fv), 32'd5);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            tick();
            enable = ($urandom_range(0, 79) != 0);
            sample_strobe = 1'($urandom_range(0, 1));
            rate_wr = ($urandom_range(0, 24) == 0);
            rate_in = 8'($urandom_range(0, 6));
        end

        // 6: drop enable, re-enable, then async reset between edges
        tick();
        enable = 1'b1; sample_strobe = 1'b1; rate_wr = 1'b0;
        repeat (7) tick();
        enable = 1'b0;
        tick();
        @(negedge clock);
        chk("t6_off_cic_enable", 32'(cic_enable), 32'd0);
        chk("t6_off_strobe_in", 32'(strobe_in), 32'd0);
        tick();
        enable = 1'b1;
        tick();
        @(negedge clock);
        chk("t6_rewarm", 32'(settling), 32'd1);
        tick();
        rate_wr = 1'b1; rate_in = 8'd9;
        tick();
        rate_wr = 1'b0;
        @(negedge clock);
        chk("t6_pending", 32'(rate_pending), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_cic_enable", 32'(cic_enable), 32'd0);
        chk("t6_rst_strobe_in", 32'(strobe_in), 32'd0);
        chk("t6_rst_strobe_out", 32'(strobe_out), 32'd0);
        chk("t6_rst_valid", 32'(valid_out), 32'd0);
        chk("t6_rst_settling", 32'(settling), 32'd0);
        chk("t6_rst_pending", 32'(rate_pending), 32'd0);
        chk("t6_rst_rate", 32'(rate_cur), 32'd16);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        chk("t6_pend_discarded", 32'(rate_cur), 32'd16);
        chk("t6_running", 32'(cic_enable), 32'd1);
        run_chk = 0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_decim_sched.md
Name: cic_decim_sched

Overview:
- Sequencing controller for the CIC decimator.
- Turns a raw input sample strobe into the decimator's strobe_in, strobe_out and enable.
- Decimation rate is programmable, and rate updates take effect only on output-sample boundaries.
- Masks the comb warm-up transient so downstream logic sees only settled output samples.
- Sits between the front-end sample-rate strobe generator and cic_decim; configured from the control-register bank.

Parameters:
- RATE_W, 8: width of the decimation-rate field.
- STAGES, 4: CIC stage count; sets the number of warm-up outputs to mask.
- DEFAULT_RATE, 16: rate loaded at reset. Legal range is 1..2^RATE_W-1.

Ports:
- clock, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: run request from the control register.
- sample_strobe, input, 1: one-cycle pulse per input sample.
- rate_in, input, RATE_W: requested decimation rate.
- rate_wr, input, 1: one-cycle write pulse for rate_in.
- cic_enable, output, 1: enable to the decimator.
- strobe_in, output, 1: input-sample strobe to the decimator.
- strobe_out, output, 1: output-sample strobe to the decimator.
- valid_out, output, 1: strobe_out qualified by warm-up completion.
- rate_cur, output, RATE_W: rate currently in force.
- rate_pending, output, 1: a written rate is waiting for a boundary.
- rate_err, output, 1: one-cycle pulse when a write is rejected.
- settling, output, 1: high while in the WARMUP state.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clock, reset_n). All state is registered.
- Reset values:
  - cic_enable, strobe_in, strobe_out, valid_out, rate_pending, rate_err, settling = 0.
  - rate_cur = DEFAULT_RATE.
  - Decimation counter = 0; warm-up counter = 0; state = IDLE.
- States:
  - IDLE:
    - Outputs cic_enable = 0 and no strobes. Counters are held at 0.
    - On enable = 1, go to WARMUP and load the warm-up counter with STAGES.
  - WARMUP:
    - cic_enable = 1. strobe_in and strobe_out are generated as described below; valid_out = 0; settling = 1.
    - Each strobe_out decrements the warm-up counter.
    - When the strobe_out that brings the counter to 0 occurs, go to RUN on the next cycle. The first STAGES output strobes are therefore masked.
  - RUN:
    - valid_out = strobe_out.
  - Any state: enable = 0 sends the block to IDLE on the next clock edge.
- Strobe timing:
  - strobe_in is registered: it goes high one cycle after sample_strobe, while state is not IDLE.
  - The decimation counter counts input strobes from rate_cur-1 down to 0.
  - strobe_out is asserted in the same cycle as the strobe_in that finds the counter at 0; the counter then reloads to rate_cur-1.
  - The first strobe_out after entering WARMUP occurs on the 1st strobe_in (counter starts at 0).
  - With rate_cur = 1, strobe_out = strobe_in.
- Rate writes:
  - rate_wr with rate_in = 0: the write is ignored, rate_err pulses one cycle, and any earlier pending value is kept.
  - Valid write: the value is held in a pending register and rate_pending = 1. If another write arrives before the boundary, the latest value wins.
  - In IDLE, a pending rate is applied on the next cycle and rate_pending clears.
  - Otherwise the pending rate is applied on the cycle after a strobe_out. At that point:
    - rate_cur updates and rate_pending clears;
    - the counter reloads to new rate-1;
    - the state goes to WARMUP and the warm-up counter reloads with STAGES (comb history is invalid after a rate change).
  - A rate_wr in the same cycle as a strobe_out is not applied at that boundary; it waits for the following strobe_out.
- Simultaneous events:
  - enable falling with rate_wr: the write is captured and applied in IDLE.
  - sample_strobe while enable = 0: ignored.
  - A sample_strobe in the cycle enable rises is counted; its strobe_in appears in the next cycle.
- Mid-operation reset: all outputs go to their reset values immediately (asynchronous). Any pending rate is discarded.

Test Plan:
1. Reset with DEFAULT_RATE = 16, then enable = 1 and sample_strobe = 1 every cycle.
   -> strobe_in high continuously from the 2nd cycle. strobe_out on strobe_in #1, #17, #33, …. valid_out first high on output #5. settling high until then.
2. In RUN, write rate_in = 4 midway through a decimation period.
   -> rate_pending = 1. rate_cur stays 16 until the next strobe_out, then becomes 4. Four masked outputs follow, then valid_out every 4th strobe_in.
3. rate_wr with 0, then 3 and 5 in consecutive cycles.
   -> rate_err pulses once, for the 0 write only. The applied rate is 5.
4. rate_wr coincident with strobe_out.
   -> the rate is applied at the subsequent strobe_out, not the coincident one.
5. Rate 1 and sample_strobe every 3rd cycle.
   -> strobe_out = strobe_in. valid_out begins at the 5th strobe.
6. Drop enable mid-period, then assert reset_n = 0 asynchronously between edges.
   -> dropping enable: cic_enable = 0 and no strobes from the next edge; re-enabling restarts WARMUP.
   -> reset_n low: all outputs 0 immediately and rate_cur = 16.
